rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter and sequencer for the integer register file. It shares the single register-file write port between the ALU write-back path and the load/store unit (LSU) load-return path, and drives the per-register `en` inputs of the 32 `register` instances. It also keeps a pending-load scoreboard that the hazard logic uses to stall readers of registers with an outstanding load.

## Interface
Parameters:
- `WIDTH`, 32: data width.
- `NREG`, 32: number of architectural registers.
- `AW`, 5: register address width, equal to log2(`NREG`).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU write-back request.
- `alu_rd`  in  AW  ALU destination register.
- `alu_data`  in  WIDTH  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `lsu_valid`  in  1  load-return write-back request.
- `lsu_rd`  in  AW  load destination register.
- `lsu_data`  in  WIDTH  load data.
- `lsu_ready`  out  1  LSU request accepted this cycle.
- `lsu_issue`  in  1  a load to `lsu_issue_rd` was issued this cycle.
- `lsu_issue_rd`  in  AW  destination register of the issued load.
- `wr_en`  out  NREG  one-hot register enables, registered.
- `wr_data`  out  WIDTH  write data to all registers, registered.
- `pend`  out  NREG  pending-load bitmap, registered.

## Operation
- Handshake is valid/ready. A transfer occurs when both `valid` and `ready` are high.
  - The requester holds `valid`, `rd` and `data` stable until `ready` is seen.
  - `ready` is combinational from the current-cycle valids and the arbiter state.
  - At most one transfer is accepted per cycle.
- Arbitration:
  - A single valid request is granted immediately.
  - When both requests are valid, the winner is selected by policy (see Configuration).
  - State bit `last` records the most recent winner and updates on every transfer. Reset value: `last` = LSU.
- Write stage: the accepted request is registered.
  - In the next cycle, `wr_en` is one-hot at bit `rd` and `wr_data` carries the data.
  - If no request was accepted, `wr_en` is all zero and `wr_data` holds its previous value.
- `rd` = 0 (x0) is accepted and handshaken normally but produces `wr_en` all zero, so x0 is never written.
- Scoreboard:
  - `lsu_issue` with `lsu_issue_rd` ≠ 0 sets `pend[lsu_issue_rd]`.
  - An accepted LSU transfer clears `pend[lsu_rd]`.
  - ALU transfers never touch `pend`.
  - If an issue and a clear hit the same register in the same cycle, the set wins (a new load supersedes the returning one).
  - `pend[0]` is always 0.
- Reset values: `wr_en` = 0, `wr_data` = 0, `pend` = 0, `last` = LSU. While `rst` is high, `alu_ready` and `lsu_ready` are 0.
- Reset during operation: any in-flight write-stage entry is dropped, with no `wr_en` pulse in the following cycle. All `pend` bits clear.

## Timing
- A transfer accepted in cycle N drives `wr_en`/`wr_data` in cycle N+1. The register `Q` reflects the write from cycle N+2.
- A `pend` set or clear caused in cycle N is visible on `pend` in cycle N+1.
- Throughput is one write per cycle. Back-to-back transfers to the same `rd` produce consecutive `wr_en` pulses, and the last one wins.
- The combinational path is valid → ready only. No combinational path runs from any input to `wr_en`, `wr_data` or `pend`.

## Configuration
- `RF_WB_RR_EN` defined: round-robin policy. On contention, the requester that is not `last` wins, so neither side waits more than one cycle while the other keeps requesting.
- `RF_WB_RR_EN` undefined: fixed priority, LSU always wins. The ALU can be starved by continuous LSU returns. `last` is still maintained but unused.

## Test plan
- Reset, then `alu_valid`=1, `alu_rd`=5, `alu_data`=0xDEADBEEF → `alu_ready`=1 in the same cycle; next cycle `wr_en`=0x00000020 and `wr_data`=0xDEADBEEF; the cycle after, `wr_en`=0.
- ALU (rd=3, 0x11) and LSU (rd=4, 0x22) both valid and held for 3 cycles:
  - With `RF_WB_RR_EN`: grants are ALU, LSU, ALU, so `wr_en` = bit 3, bit 4, bit 3.
  - Without it: grants are LSU, LSU, LSU, and `alu_ready` stays 0.
- `alu_valid` with `alu_rd`=0, data 0xFFFFFFFF → `alu_ready`=1, `wr_en`=0 in the next cycle.
- `lsu_issue` with rd=7, then two cycles later an LSU transfer with rd=7 → `pend[7]`=1 from the cycle after the issue until the cycle after the transfer, then 0. Issue with rd=0 → `pend` stays 0.
- Same-cycle `lsu_issue` rd=9 and accepted LSU transfer rd=9, with `pend[9]` already 1 → `pend[9]` remains 1 and `wr_en` bit 9 pulses.
- Assert `rst` in the cycle after an accepted transfer with rd=6 → `wr_en` stays 0 and `pend`=0. After release, a new ALU request is granted first.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-back arbiter for the integer register file.
// Shares the single write port between ALU write-back and LSU load return,
// drives one-hot register enables, and tracks outstanding loads in `pend`.
// Optional feature: define RF_WB_RR_EN for round-robin arbitration;
// otherwise the LSU has fixed priority.
module rf_wb_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  output logic             alu_ready,
  input  logic             lsu_valid,
  input  logic [AW-1:0]    lsu_rd,
  input  logic [WIDTH-1:0] lsu_data,
  output logic             lsu_ready,
  input  logic             lsu_issue,
  input  logic [AW-1:0]    lsu_issue_rd,
  output logic [NREG-1:0]  wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic [NREG-1:0]  pend
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_t;

  src_t             last_q;
  logic             alu_gnt;
  logic             lsu_gnt;
  logic             lsu_wins;
  logic             acc;
  logic [AW-1:0]    acc_rd;
  logic [WIDTH-1:0] acc_data;
  logic [NREG-1:0]  pend_d;

  // Grant selection: single requester wins outright, contention goes to policy.
  always_comb begin
    alu_gnt  = 1'b0;
    lsu_gnt  = 1'b0;
`ifdef RF_WB_RR_EN
    lsu_wins = (last_q == SRC_ALU);
`else
    // Fixed priority: the LSU wins regardless of the last winner.
    lsu_wins = (last_q == SRC_ALU) || (last_q == SRC_LSU);
`endif
    if (!rst) begin
      if (alu_valid && lsu_valid) begin
        lsu_gnt = lsu_wins;
        alu_gnt = !lsu_wins;
      end else begin
        alu_gnt = alu_valid;
        lsu_gnt = lsu_valid;
      end
    end
  end

  assign alu_ready = alu_gnt;
  assign lsu_ready = lsu_gnt;

  // Mux the accepted request and compute the next scoreboard value.
  always_comb begin
    acc      = alu_gnt | lsu_gnt;
    acc_rd   = lsu_gnt ? lsu_rd   : alu_rd;
    acc_data = lsu_gnt ? lsu_data : alu_data;
    pend_d   = pend;
    if (lsu_gnt)
      pend_d[lsu_rd] = 1'b0;
    // Set applied after clear so a new issue supersedes a same-cycle return.
    if (lsu_issue)
      pend_d[lsu_issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Write stage, scoreboard and last-winner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= '0;
      wr_data <= '0;
      pend    <= '0;
      last_q  <= SRC_LSU;
    end else begin
      wr_en <= '0;
      if (acc && (acc_rd != '0))
        wr_en[acc_rd] <= 1'b1;
      if (acc) begin
        wr_data <= acc_data;
        last_q  <= lsu_gnt ? SRC_LSU : SRC_ALU;
      end
      pend <= pend_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed-vector bench for rf_wb_arbiter.
// Inputs change 1 ns after the rising edge; ready is sampled 2 ns later,
// registered outputs 1 ns after the following rising edge.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        lsu_issue;
  logic [4:0]  lsu_issue_rd;
  logic [31:0] wr_en;
  logic [31:0] wr_data;
  logic [31:0] pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.WIDTH(32), .NREG(32), .AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .lsu_valid    (lsu_valid),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .lsu_ready    (lsu_ready),
    .lsu_issue    (lsu_issue),
    .lsu_issue_rd (lsu_issue_rd),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .pend         (pend)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    lsu_issue = 1'b0; lsu_issue_rd = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] exp_en   [3];
  logic [31:0] exp_data [3];
  logic        exp_ardy [3];

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    // Ready must stay low while reset is held, even with requests pending.
    alu_valid = 1'b1; lsu_valid = 1'b1;
    #2;
    check("rst_alu_ready", {31'b0, alu_ready}, 32'd0);
    check("rst_lsu_ready", {31'b0, lsu_ready}, 32'd0);
    tick();
    check("rst_wr_en", wr_en, 32'h0);
    check("rst_wr_data", wr_data, 32'h0);
    check("rst_pend", pend, 32'h0);
    do_reset();

    // Single ALU write to x5.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #2;
    check("alu5_ready", {31'b0, alu_ready}, 32'd1);
    check("alu5_lsu_ready", {31'b0, lsu_ready}, 32'd0);
    tick();
    idle_inputs();
    check("alu5_wr_en", wr_en, 32'h0000_0020);
    check("alu5_wr_data", wr_data, 32'hDEADBEEF);
    tick();
    check("alu5_wr_en_off", wr_en, 32'h0);
    check("alu5_wr_data_hold", wr_data, 32'hDEADBEEF);

    // Contention, starting from reset (last = LSU).
    do_reset();
`ifdef RF_WB_RR_EN
    exp_en   = '{32'h8, 32'h10, 32'h8};
    exp_data = '{32'h11, 32'h22, 32'h11};
    exp_ardy = '{1'b1, 1'b0, 1'b1};
`else
    exp_en   = '{32'h10, 32'h10, 32'h10};
    exp_data = '{32'h22, 32'h22, 32'h22};
    exp_ardy = '{1'b0, 1'b0, 1'b0};
`endif
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      #2;
      check($sformatf("cont%0d_alu_ready", i), {31'b0, alu_ready}, {31'b0, exp_ardy[i]});
      check($sformatf("cont%0d_lsu_ready", i), {31'b0, lsu_ready}, {31'b0, !exp_ardy[i]});
      @(posedge clk);
      #1;
      check($sformatf("cont%0d_wr_en", i), wr_en, exp_en[i]);
      check($sformatf("cont%0d_wr_data", i), wr_data, exp_data[i]);
    end
    idle_inputs();
    tick();
    check("cont_wr_en_off", wr_en, 32'h0);

    // Write to x0 is handshaken but never enables a register.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    #2;
    check("x0_alu_ready", {31'b0, alu_ready}, 32'd1);
    tick();
    idle_inputs();
    check("x0_wr_en", wr_en, 32'h0);

    // Load to x7: issue, wait, return.
    lsu_issue = 1'b1; lsu_issue_rd = 5'd7;
    tick();
    idle_inputs();
    check("ld7_pend_set", pend, 32'h0000_0080);
    tick();
    check("ld7_pend_hold", pend, 32'h0000_0080);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    #2;
    check("ld7_lsu_ready", {31'b0, lsu_ready}, 32'd1);
    tick();
    idle_inputs();
    check("ld7_pend_clr", pend, 32'h0);
    check("ld7_wr_en", wr_en, 32'h0000_0080);
    check("ld7_wr_data", wr_data, 32'h77);

    // Issue to x0 never marks pend.
    lsu_issue = 1'b1; lsu_issue_rd = 5'd0;
    tick();
    idle_inputs();
    check("ld0_pend", pend, 32'h0);

    // Same-cycle issue and return on x9 with x9 already pending: set wins.
    lsu_issue = 1'b1; lsu_issue_rd = 5'd9;
    tick();
    check("ld9_pend_set", pend, 32'h0000_0200);
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    #2;
    check("ld9_lsu_ready", {31'b0, lsu_ready}, 32'd1);
    tick();
    idle_inputs();
    check("ld9_pend_keep", pend, 32'h0000_0200);
    check("ld9_wr_en", wr_en, 32'h0000_0200);
    check("ld9_wr_data", wr_data, 32'h99);

    // Reset mid-flight: ALU write to x6 (last becomes ALU), then reset.
    lsu_issue = 1'b1; lsu_issue_rd = 5'd10;
    tick();
    idle_inputs();
    check("ld10_pend", pend, 32'h0000_0600);
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    check("midrst_wr_en", wr_en, 32'h0);
    check("midrst_pend", pend, 32'h0);
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2;
    #2;
`ifdef RF_WB_RR_EN
    check("post_rst_alu_ready", {31'b0, alu_ready}, 32'd1);
    check("post_rst_lsu_ready", {31'b0, lsu_ready}, 32'd0);
    tick();
    check("post_rst_wr_en", wr_en, 32'h0000_0002);
`else
    check("post_rst_alu_ready", {31'b0, alu_ready}, 32'd0);
    check("post_rst_lsu_ready", {31'b0, lsu_ready}, 32'd1);
    tick();
    check("post_rst_wr_en", wr_en, 32'h0000_0004);
`endif
    idle_inputs();
    tick();
    check("final_wr_en_off", wr_en, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
